// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads the combinational instruction memory and
// feeds decode through a 2-entry skid buffer. Optional perf counters: define IFETCH_PERF_EN.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS  = 32,
    parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        misalign_err
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CNT_W   = 2;
    localparam logic [XLEN-1:0] PC_WRAP = XLEN'(MEM_WORDS * 4);
    localparam logic [CNT_W-1:0] DEPTH  = CNT_W'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    fetch_entry_t       ent0_q, ent0_d;
    fetch_entry_t       ent1_q, ent1_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic               misalign_q, misalign_d;

    logic               pop_c;
    logic               capture_c;
    fetch_entry_t       new_ent;
    logic [XLEN-1:0]    pc_inc;
    logic [XLEN-1:0]    pc_seq;

    // Next-state, PC sequencing and skid-buffer update
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        misalign_d = misalign_q;
        capture_c  = 1'b0;
        pop_c      = valid_q & out_ready;
        new_ent    = '{pc: pc_q, instr: imem_instr};
        pc_inc     = pc_q + XLEN'(4);
        pc_seq     = (pc_inc == PC_WRAP) ? '0 : pc_inc;

        if (redirect_valid) begin
            // Redirect flushes the buffer; a coinciding pop is dropped with it
            count_d = '0;
            if (redirect_pc[1:0] != 2'b00) begin
                pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
                misalign_d = 1'b1;
                state_d    = HALT;
            end else begin
                pc_d = redirect_pc;
                if (state_q == HALT) begin
                    state_d = RUN;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_en) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!fetch_en) begin
                        state_d = IDLE;
                    end else if ((count_q != DEPTH) || pop_c) begin
                        capture_c = 1'b1;
                        pc_d      = pc_seq;
                        if (imem_instr == HALT_INSTR) begin
                            state_d = HALT;
                        end
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Head is entry 0; a pop shifts entry 1 forward
            case ({capture_c, pop_c})
                2'b10: begin
                    if (count_q == '0) begin
                        ent0_d = new_ent;
                    end else begin
                        ent1_d = new_ent;
                    end
                    count_d = count_q + CNT_W'(1);
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - CNT_W'(1);
                end
                2'b11: begin
                    if (count_q == DEPTH) begin
                        ent0_d = ent1_q;
                        ent1_d = new_ent;
                    end else begin
                        ent0_d = new_ent;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end

        valid_d  = (count_d != '0);
        halted_d = (state_d == HALT);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            count_q    <= '0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] stall_cnt_q;

    // Stall = running with a full buffer that decode is not draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (capture_c) begin
                fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
            end
            if ((state_q == RUN) && (count_q == DEPTH) && !pop_c) begin
                stall_cnt_q <= stall_cnt_q + XLEN'(1);
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

    assign imem_addr    = pc_q;
    assign out_valid    = valid_q;
    assign out_instr    = ent0_q.instr;
    assign out_pc       = ent0_q.pc;
    assign halted       = halted_q;
    assign misalign_err = misalign_q;

endmodule
